// File: rtl/bist_alu_pipe_if.sv
// ---------------------------------------------------------------------------
// bist_alu_pipe_if
// Handshake and data bundle for the bist_alu_pipe two-stage ALU.
//
// Signals
//   in_valid  : producer offers an operand/opcode beat
//   in_ready  : pipe can take a beat this cycle
//   in_a/in_b : operands (WIDTH bits)
//   in_op     : 3-bit opcode
//   out_valid : result beat held on the outputs
//   out_ready : consumer takes the result this cycle
//   out_data  : result (WIDTH bits)
//   out_carry : ADD carry / SUB borrow, 0 otherwise
//   out_zero  : out_data == 0
//   out_err   : opcode was illegal
//
// Modports
//   master : the producer/consumer side (testbench or surrounding logic)
//   slave  : the ALU pipe itself
// ---------------------------------------------------------------------------
interface bist_alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/bist_alu_pipe.sv
// ---------------------------------------------------------------------------
// bist_alu_pipe
// Two-stage valid/ready ALU pipeline with an accepted-result counter.
// Stage 1 registers the operands and opcode; stage 2 registers the computed
// result and flags. Full throughput of one beat per cycle while out_ready=1,
// with backpressure propagating to in_ready once both stages hold beats.
//
// Parameters
//   WIDTH : operand/result width (4..32)
//   CNT_W : width of res_count
//
// Ports
//   clk       : single clock, rising-edge
//   rst       : asynchronous active-high reset
//   bus       : bist_alu_pipe_if.slave (input beat handshake, result beat)
//   res_count : number of results consumed since reset, wraps
// ---------------------------------------------------------------------------
module bist_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bist_alu_pipe_if.slave   bus,
    output logic [CNT_W-1:0] res_count
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    // stage 1
    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [2:0]       op1;

    // stage 2
    logic             v2;
    logic [WIDTH-1:0] data2;
    logic             carry2;
    logic             zero2;
    logic             err2;

    logic s2_load;
    logic s1_load;
    logic consume;

    // Stage 2 frees up whenever it is empty or its beat leaves this cycle;
    // stage 1 frees up when empty or when it can hand over to stage 2.
    assign s2_load = !v2 || bus.out_ready;
    assign s1_load = !v1 || s2_load;
    assign consume = v2 && bus.out_ready;

    assign bus.in_ready = s1_load;

    // -----------------------------------------------------------------------
    // Combinational ALU on the stage-1 contents
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;
    logic             shift_oor;
    logic [WIDTH-1:0] alu_data;
    logic             alu_carry;
    logic             alu_err;
    logic             alu_zero;

    assign sum_ext  = {1'b0, a1} + {1'b0, b1};
    // The extra top bit of the zero-extended difference is the borrow,
    // set exactly when a1 < b1 unsigned.
    assign diff_ext = {1'b0, a1} - {1'b0, b1};
    assign shamt    = b1[SHW-1:0];
    // Any operand B at or above WIDTH is an out-of-range shift and flushes
    // the result to zero, rather than aliasing through the low bits.
    assign shift_oor = (b1 >= WIDTH_V);

    always_comb begin
        alu_data  = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op1)
            OP_ADD: begin
                alu_data  = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_data  = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            OP_AND: alu_data = a1 & b1;
            OP_OR:  alu_data = a1 | b1;
            OP_XOR: alu_data = a1 ^ b1;
            OP_SHL: alu_data = shift_oor ? '0 : (a1 << shamt);
            OP_SHR: alu_data = shift_oor ? '0 : (a1 >> shamt);
            default: begin
                alu_data = '0;
                alu_err  = 1'b1;
            end
        endcase
    end

    assign alu_zero = (alu_data == '0);

    // -----------------------------------------------------------------------
    // Stage 1 register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            op1 <= '0;
        end else if (s1_load) begin
            // Taking no new beat while forwarding leaves a bubble.
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a1  <= bus.in_a;
                b1  <= bus.in_b;
                op1 <= bus.in_op;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 register; result fields only change when a new beat lands,
    // so they stay frozen while the consumer stalls.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            data2  <= '0;
            carry2 <= 1'b0;
            zero2  <= 1'b0;
            err2   <= 1'b0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                data2  <= alu_data;
                carry2 <= alu_carry;
                zero2  <= alu_zero;
                err2   <= alu_err;
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.out_data  = data2;
    assign bus.out_carry = carry2;
    assign bus.out_zero  = zero2;
    assign bus.out_err   = err2;

    // -----------------------------------------------------------------------
    // Consumed-result counter, free-running wrap
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_count <= '0;
        end else if (consume) begin
            res_count <= res_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bist_alu_pipe.sv
module tb_bist_alu_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bist_alu_pipe_if #(.WIDTH(WIDTH)) bif ();
    logic [CNT_W-1:0] res_count;

    bist_alu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .res_count (res_count)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             zero;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   consumed  = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit   saw_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input longint a, input longint b, input int op);
        exp_t   e;
        longint m = (longint'(1) << WIDTH) - 1;
        longint r = 0;
        e.carry = 1'b0;
        e.err   = 1'b0;
        case (op)
            0: begin r = a + b; e.carry = (r > m); end
            1: begin r = a - b; e.carry = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= WIDTH) ? 0 : (a << b);
            6: r = (b >= WIDTH) ? 0 : (a >> b);
            default: begin r = 0; e.err = 1'b1; end
        endcase
        r = r & m;
        e.data = r[WIDTH-1:0];
        e.zero = (r == 0);
        return e;
    endfunction

    // out_ready owner
    initial begin
        bif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: bif.out_ready = 1'b0;
                1: bif.out_ready = 1'b1;
                default: bif.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready", bif.in_ready, (sb.size() < 2) || bif.out_ready);
                check("res_count", res_count, consumed % (1 << CNT_W));
                if (!bif.in_ready) saw_stall = 1;
                if (bif.out_valid) begin
                    if (sb.size() == 0) begin
                        check("no_stale_output", bif.out_valid, 0);
                        if (bif.out_ready) consumed++;
                    end else begin
                        e = sb[0];
                        check("out_data", bif.out_data, e.data);
                        check("out_carry", bif.out_carry, e.carry);
                        check("out_zero", bif.out_zero, e.zero);
                        check("out_err", bif.out_err, e.err);
                        if (bif.out_ready) begin
                            void'(sb.pop_front());
                            consumed++;
                        end
                    end
                end
            end
        end
    end

    // Offer one beat, retry until accepted; returns at accept edge + 1.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
        bit acc = 0;
        int guard = 0;
        bif.in_valid = 1'b1;
        bif.in_a = a;
        bif.in_b = b;
        bif.in_op = op;
        while (!acc) begin
            @(negedge clk);
            acc = bif.in_ready;
            #1;
            if (acc) sb.push_back(model(a, b, op));
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                check("accept_timeout", guard, 0);
                break;
            end
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        ready_mode = 1;
        while (sb.size() > 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2:0] op, input logic [WIDTH-1:0] d, input logic c,
                            input logic z, input logic er);
        ready_mode = 1;
        drive(a, b, op);
        check({name, "_lat1"}, bif.out_valid, 0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, bif.out_valid, 1);
        check({name, "_data"}, bif.out_data, d);
        check({name, "_carry"}, bif.out_carry, c);
        check({name, "_zero"}, bif.out_zero, z);
        check({name, "_err"}, bif.out_err, er);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_res_count", res_count, 0);
        sb.delete();
        consumed = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_in_ready", bif.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.in_valid = 1'b0;
        bif.in_a = '0;
        bif.in_b = '0;
        bif.in_op = '0;
        #2;
        check("init_out_valid", bif.out_valid, 0);
        check("init_out_data", bif.out_data, 0);
        check("init_out_flags", {bif.out_carry, bif.out_zero, bif.out_err}, 0);
        check("init_res_count", res_count, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("init_in_ready", bif.in_ready, 1);

        directed("add_carry", 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0, 1'b0);
        directed("sub_borrow", 8'h05, 8'h07, 3'b001, 8'hFE, 1'b1, 1'b0, 1'b0);
        directed("sub_zero", 8'h07, 8'h07, 3'b001, 8'h00, 1'b0, 1'b1, 1'b0);
        directed("illegal_op", 8'hAA, 8'h55, 3'b111, 8'h00, 1'b0, 1'b1, 1'b1);
        directed("shl_oor", 8'h81, 8'h09, 3'b101, 8'h00, 1'b0, 1'b1, 1'b0);
        directed("shr_1", 8'h81, 8'h01, 3'b110, 8'h40, 1'b0, 1'b0, 1'b0);
        directed("and", 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0);
        directed("or", 8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0);
        directed("xor", 8'hFF, 8'h0F, 3'b100, 8'hF0, 1'b0, 1'b0, 1'b0);
        drain();

        // Ten back-to-back beats with a four-cycle consumer stall.
        do_reset();
        saw_stall = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    drive(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
            end
            begin
                ready_mode = 1;
                repeat (3) @(posedge clk);
                #1 ready_mode = 0;
                repeat (4) @(posedge clk);
                #1 ready_mode = 1;
            end
        join
        drain();
        check("stream_stalled", saw_stall, 1);
        check("stream_count", res_count, 10);

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++)
            drive(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 6)));
        drain();
        check("wrap_count", res_count, 1);

        // Randomised traffic with random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 11)) : WIDTH'($urandom);
            drive(a, b, 3'($urandom_range(0, 7)));
        end
        drain();

        // Reset with both stages holding beats.
        ready_mode = 0;
        drive(8'h11, 8'h22, 3'b000);
        drive(8'h33, 8'h44, 3'b000);
        check("full_out_valid", bif.out_valid, 1);
        check("full_in_ready", bif.in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bif.out_valid, 0);
        check("midrst_res_count", res_count, 0);
        check("midrst_out_data", bif.out_data, 0);
        sb.delete();
        consumed = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        ready_mode = 1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", bif.out_valid, 0);
        check("post_rst_count", res_count, 0);
        directed("post_rst_add", 8'h01, 8'h02, 3'b000, 8'h03, 1'b0, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
